stack_program_counter: RTL and testbench

STACK_PROGRAM_COUNTER -- requirements
Module: stack_program_counter

---
 rtl/stack_program_counter.sv | 121 ++++++++++++
 tb/tb_stack_program_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_program_counter.sv
// Program counter with a return-address stack for CALL/RET.
// Sticky overflow/underflow flags record CALL-on-full and RET-on-empty.
module stack_program_counter #(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    localparam int              CW           = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] new_count,
    input  logic [WIDTH-1:0] offset,
    input  logic             clear_err,
    output logic [WIDTH-1:0] count,
    output logic [CW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_JUMP   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } op_e;

    logic [WIDTH-1:0] count_q, count_d;
    logic [CW-1:0]    depth_q, depth_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic             push_en;
    logic [WIDTH-1:0] push_data;
    logic [CW-1:0]    top_idx;
    logic [WIDTH-1:0] top_data;
    logic             full_w;
    logic             empty_w;

    assign full_w   = (depth_q == CW'(DEPTH));
    assign empty_w  = (depth_q == '0);
    assign top_idx  = depth_q - CW'(1);
    assign top_data = stack_mem[top_idx[SW-1:0]];

    always_comb begin
        count_d     = count_q;
        depth_d     = depth_q;
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;
        push_en     = 1'b0;
        push_data   = count_q + WIDTH'(1);

        // A new error event overrides a simultaneous clear_err.
        case (op_e'(op))
            OP_INC: begin
                count_d = count_q + WIDTH'(1);
            end
            OP_JUMP: begin
                count_d = new_count;
            end
            OP_BRANCH: begin
                count_d = count_q + offset;
            end
            OP_CALL: begin
                if (!full_w) begin
                    push_en = 1'b1;
                    depth_d = depth_q + CW'(1);
                    count_d = new_count;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            OP_RET: begin
                if (!empty_w) begin
                    count_d = top_data;
                    depth_d = depth_q - CW'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q     <= RESET_VECTOR;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is left unreset; entries at or above depth are never read.
    always_ff @(posedge clock) begin
        if (push_en && reset) begin
            stack_mem[depth_q[SW-1:0]] <= push_data;
        end
    end

    assign count     = count_q;
    assign depth     = depth_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_program_counter.sv
// Directed bench for stack_program_counter (WIDTH=16, DEPTH=8, RESET_VECTOR=0x0100).
module tb_stack_program_counter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             clock;
    logic             reset;
    logic [2:0]       op;
    logic [WIDTH-1:0] new_count;
    logic [WIDTH-1:0] offset;
    logic             clear_err;
    logic [WIDTH-1:0] count;
    logic [CW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int total = 0;
    int bad   = 0;

    stack_program_counter #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VECTOR(16'h0100)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .op       (op),
        .new_count(new_count),
        .offset   (offset),
        .clear_err(clear_err),
        .count    (count),
        .depth    (depth),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One operation per cycle: drive at negedge, sample 1 time unit after posedge.
    task automatic do_op(input logic [2:0] o, input logic [15:0] nc,
                         input logic [15:0] off, input logic clr);
        @(negedge clock);
        op        = o;
        new_count = nc;
        offset    = off;
        clear_err = clr;
        @(posedge clock);
        #1;
        op        = 3'd0;
        clear_err = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        op = 3'd0; new_count = '0; offset = '0; clear_err = 1'b0;
        reset = 1'b0;
        #12;
        total++; if (count !== 16'h0100) begin bad++; $display("[TB] FAIL reset_count got=%h exp=0100", count); end
        total++; if (depth !== 4'd0) begin bad++; $display("[TB] FAIL reset_depth got=%0d exp=0", depth); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_err ovf=%b unf=%b exp 0/0", overflow, underflow); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_inc();
        logic [15:0] exp_c;
        for (int i = 1; i <= 3; i++) begin
            do_op(3'd1, 16'h0, 16'h0, 1'b0);
            exp_c = 16'h0100 + 16'(i);
            total++; if (count !== exp_c) begin bad++; $display("[TB] FAIL inc_%0d got=%h exp=%h", i, count, exp_c); end
        end
        total++; if (depth !== 4'd0 || empty !== 1'b1) begin bad++; $display("[TB] FAIL inc_stack depth=%0d empty=%b exp 0/1", depth, empty); end
    endtask

    task automatic test_hold_reserved();
        do_op(3'd0, 16'hAAAA, 16'h5555, 1'b0);
        total++; if (count !== 16'h0103) begin bad++; $display("[TB] FAIL hold got=%h exp=0103", count); end
        do_op(3'd6, 16'hAAAA, 16'h5555, 1'b0);
        do_op(3'd7, 16'hBBBB, 16'h5555, 1'b0);
        total++; if (count !== 16'h0103 || depth !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++; $display("[TB] FAIL reserved count=%h depth=%0d ovf=%b unf=%b exp 0103/0/0/0", count, depth, overflow, underflow);
        end
    endtask

    task automatic test_wrap_branch();
        do_op(3'd2, 16'hFFFF, 16'h0, 1'b0);
        total++; if (count !== 16'hFFFF) begin bad++; $display("[TB] FAIL jump got=%h exp=ffff", count); end
        do_op(3'd1, 16'h0, 16'h0, 1'b0);
        total++; if (count !== 16'h0000) begin bad++; $display("[TB] FAIL inc_wrap got=%h exp=0000", count); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("[TB] FAIL wrap_err ovf=%b unf=%b exp 0/0", overflow, underflow); end
        do_op(3'd2, 16'h0010, 16'h0, 1'b0);
        do_op(3'd3, 16'h0, 16'hFFF0, 1'b0);
        total++; if (count !== 16'h0000) begin bad++; $display("[TB] FAIL branch_neg got=%h exp=0000", count); end
        do_op(3'd3, 16'h0, 16'h0025, 1'b0);
        total++; if (count !== 16'h0025) begin bad++; $display("[TB] FAIL branch_pos got=%h exp=0025", count); end
        do_op(3'd3, 16'h0, 16'hFFFF, 1'b0);
        total++; if (count !== 16'h0024) begin bad++; $display("[TB] FAIL branch_m1 got=%h exp=0024", count); end
    endtask

    task automatic test_call_ret();
        do_op(3'd2, 16'h0020, 16'h0, 1'b0);
        do_op(3'd4, 16'h0400, 16'h0, 1'b0);
        total++; if (count !== 16'h0400 || depth !== 4'd1) begin bad++; $display("[TB] FAIL call count=%h depth=%0d exp 0400/1", count, depth); end
        do_op(3'd1, 16'h0, 16'h0, 1'b0);
        total++; if (count !== 16'h0401) begin bad++; $display("[TB] FAIL call_inc got=%h exp=0401", count); end
        do_op(3'd5, 16'h0, 16'h0, 1'b0);
        total++; if (count !== 16'h0021 || depth !== 4'd0 || empty !== 1'b1) begin
            bad++; $display("[TB] FAIL ret count=%h depth=%0d empty=%b exp 0021/0/1", count, depth, empty);
        end
    endtask

    task automatic test_nested();
        logic [15:0] exp_c;
        do_op(3'd2, 16'h1000, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            do_op(3'd4, 16'h2000 + 16'(i * 16), 16'h0, 1'b0);
            total++; if (depth !== 4'(i + 1)) begin bad++; $display("[TB] FAIL nest_depth_%0d got=%0d exp=%0d", i, depth, i + 1); end
        end
        total++; if (full !== 1'b1 || empty !== 1'b0) begin bad++; $display("[TB] FAIL nest_full full=%b empty=%b exp 1/0", full, empty); end
        do_op(3'd4, 16'h3333, 16'h0, 1'b0);
        total++; if (count !== 16'h2070 || depth !== 4'd8 || overflow !== 1'b1) begin
            bad++; $display("[TB] FAIL call_full count=%h depth=%0d ovf=%b exp 2070/8/1", count, depth, overflow);
        end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            do_op(3'd5, 16'h0, 16'h0, 1'b0);
            exp_c = (k == 0) ? 16'h1001 : 16'h2000 + 16'((k - 1) * 16) + 16'h1;
            total++; if (count !== exp_c) begin bad++; $display("[TB] FAIL unwind_%0d got=%h exp=%h", k, count, exp_c); end
        end
        total++; if (empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("[TB] FAIL unwind_end empty=%b unf=%b exp 1/0", empty, underflow); end
        do_op(3'd5, 16'h0, 16'h0, 1'b0);
        total++; if (count !== 16'h1001 || depth !== 4'd0 || underflow !== 1'b1) begin
            bad++; $display("[TB] FAIL ret_empty count=%h depth=%0d unf=%b exp 1001/0/1", count, depth, underflow);
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_clear_err();
        do_op(3'd0, 16'h0, 16'h0, 1'b1);
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("[TB] FAIL clear ovf=%b unf=%b exp 0/0", overflow, underflow); end
        for (int i = 0; i < DEPTH; i++) do_op(3'd4, 16'h0500 + 16'(i), 16'h0, 1'b0);
        do_op(3'd4, 16'h0600, 16'h0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b exp=1", overflow); end
        do_op(3'd4, 16'h0600, 16'h0, 1'b1);
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL clear_vs_event got=%b exp=1", overflow); end
        do_op(3'd0, 16'h0, 16'h0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_hold got=%b exp=1", overflow); end
        do_op(3'd0, 16'h0, 16'h0, 1'b1);
        total++; if (overflow !== 1'b0 || count !== 16'h0507 || depth !== 4'd8) begin
            bad++; $display("[TB] FAIL clear_alone ovf=%b count=%h depth=%0d exp 0/0507/8", overflow, count, depth);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) do_op(3'd4, 16'h0700 + 16'(i * 2), 16'h0, 1'b0);
        total++; if (depth !== 4'd3) begin bad++; $display("[TB] FAIL pre_reset_depth got=%0d exp=3", depth); end
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        total++; if (count !== 16'h0100 || depth !== 4'd0 || empty !== 1'b1) begin
            bad++; $display("[TB] FAIL async_reset count=%h depth=%0d empty=%b exp 0100/0/1", count, depth, empty);
        end
        #1;
        reset = 1'b1;
        do_op(3'd5, 16'h0, 16'h0, 1'b0);
        total++; if (underflow !== 1'b1 || count !== 16'h0100) begin
            bad++; $display("[TB] FAIL ret_after_reset unf=%b count=%h exp 1/0100", underflow, count);
        end
        // Reset held across a CALL edge must win over the push.
        @(negedge clock);
        op = 3'd4; new_count = 16'h0900; reset = 1'b0;
        @(posedge clock);
        #1;
        op = 3'd0;
        total++; if (count !== 16'h0100 || depth !== 4'd0 || underflow !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_during_call count=%h depth=%0d unf=%b exp 0100/0/0", count, depth, underflow);
        end
        @(negedge clock);
        reset = 1'b1;
        do_op(3'd1, 16'h0, 16'h0, 1'b0);
        total++; if (count !== 16'h0101) begin bad++; $display("[TB] FAIL first_after_reset got=%h exp=0101", count); end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_hold_reserved();
        test_wrap_branch();
        test_call_ret();
        test_nested();
        test_clear_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
